imem_responder: RTL and testbench

Instruction-memory responder: the memory-side end of the core's fetch interface. It accepts fetch requests (read strobe plus byte address), holds at most two requests outstanding, and returns each instruction word together with its request address after a fixed latency, strictly in request order. It sits between the fetch stage and the instruction SRAM, and takes in-system-programming (ISP) writes into the same array.

---
 rtl/imem_pkg.sv | 17 +
 rtl/imem_sram.sv | 39 +++
 rtl/imem_responder.sv | 126 ++++++++++++
 tb/tb_imem_responder.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared constants and the pipeline stage record for the instruction-memory responder.
package imem_pkg;

  localparam int unsigned IMEM_DATA_W     = 32;
  localparam int unsigned IMEM_ADDR_W     = 20;
  localparam int unsigned MAX_OUTSTANDING = 2;

  localparam logic [IMEM_DATA_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic                   valid;
    logic [IMEM_ADDR_W-1:0] addr;
    logic [IMEM_DATA_W-1:0] data;
    logic                   err;
  } imem_stage_t;

endpackage

// File: rtl/imem_sram.sv
// Instruction array: one synchronous read-first read port, one write port.
module imem_sram #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned INDEX_BITS = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  re_i,
  input  logic [INDEX_BITS-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  input  logic                  we_i,
  input  logic [INDEX_BITS-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i
);

  localparam int unsigned Depth = 1 << INDEX_BITS;

  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Array contents are deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read register holds its value between reads so the response data stays stable.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_responder.sv
// Fetch-side responder: fixed-latency, in-order, at most two outstanding requests.
// Optional address checking is enabled by defining IMEM_ERR_CHECK_EN.
module imem_responder
  import imem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = IMEM_DATA_W,
  parameter int unsigned ADDRESS_BITS = IMEM_ADDR_W,
  parameter int unsigned INDEX_BITS   = 10,
  parameter int unsigned LATENCY      = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    read_i,
  input  logic [ADDRESS_BITS-1:0] read_address_i,
  output logic                    ready_o,
  input  logic                    flush_i,
  output logic                    out_valid_o,
  output logic [ADDRESS_BITS-1:0] out_addr_o,
  output logic [DATA_WIDTH-1:0]   out_data_o,
  output logic                    out_err_o,
  input  logic                    isp_write_i,
  input  logic [INDEX_BITS-1:0]   isp_address_i,
  input  logic [DATA_WIDTH-1:0]   isp_data_i
);

  logic                    accept;
  logic                    req_err;
  logic [INDEX_BITS-1:0]   req_index;
  logic [DATA_WIDTH-1:0]   sram_rdata;
  logic [1:0]              count_q, count_d;
  logic                    s1_valid_q;
  logic                    s1_err_q;
  logic [ADDRESS_BITS-1:0] s1_addr_q;
  imem_stage_t [LATENCY-1:0] st;

  assign ready_o   = (count_q != 2'(MAX_OUTSTANDING));
  assign accept    = read_i & ready_o;
  assign req_index = read_address_i[INDEX_BITS+1:2];

`ifdef IMEM_ERR_CHECK_EN
  assign req_err = (|read_address_i[1:0]) | (|read_address_i[ADDRESS_BITS-1:INDEX_BITS+2]);
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{read_address_i[1:0], read_address_i[ADDRESS_BITS-1:INDEX_BITS+2]};
  assign req_err = 1'b0;
`endif

  imem_sram #(
    .DATA_WIDTH (DATA_WIDTH),
    .INDEX_BITS (INDEX_BITS)
  ) u_sram (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .re_i    (accept),
    .raddr_i (req_index),
    .rdata_o (sram_rdata),
    .we_i    (isp_write_i),
    .waddr_i (isp_address_i),
    .wdata_i (isp_data_i)
  );

  // Flush drops everything in flight but keeps a request accepted in the same cycle.
  always_comb begin
    count_d = count_q;
    if (flush_i) begin
      count_d = {1'b0, accept};
    end else if (accept && !out_valid_o) begin
      count_d = count_q + 2'd1;
    end else if (!accept && out_valid_o) begin
      count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q    <= '0;
      s1_valid_q <= 1'b0;
      s1_err_q   <= 1'b0;
      s1_addr_q  <= '0;
    end else begin
      count_q    <= count_d;
      s1_valid_q <= accept;
      if (accept) begin
        s1_err_q  <= req_err;
        s1_addr_q <= read_address_i;
      end
    end
  end

  // Stage 1 data comes straight from the array's read register.
  always_comb begin
    st[0].valid = s1_valid_q;
    st[0].addr  = s1_addr_q;
    st[0].data  = s1_err_q ? NOP_INSTR : sram_rdata;
    st[0].err   = s1_err_q;
  end

  // Payload only moves with a valid entry so the outputs hold while idle.
  for (genvar k = 1; k < LATENCY; k++) begin : g_stage
    imem_stage_t stage_q, stage_d;

    always_comb begin
      stage_d       = stage_q;
      stage_d.valid = 1'b0;
      if (st[k-1].valid && !flush_i) begin
        stage_d = st[k-1];
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        stage_q <= '0;
      end else begin
        stage_q <= stage_d;
      end
    end

    assign st[k] = stage_q;
  end

  assign out_valid_o = st[LATENCY-1].valid;
  assign out_addr_o  = st[LATENCY-1].addr;
  assign out_data_o  = st[LATENCY-1].data;
  assign out_err_o   = st[LATENCY-1].err;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder at LATENCY=2; expectations follow IMEM_ERR_CHECK_EN.
module tb_imem_responder;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 20;
  localparam int unsigned IW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          read;
  logic [AW-1:0] read_address;
  logic          ready;
  logic          flush;
  logic          out_valid;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic          out_err;
  logic          isp_write;
  logic [IW-1:0] isp_address;
  logic [DW-1:0] isp_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          err;
  } resp_t;

  resp_t resp_q[$];

  imem_responder #(
    .DATA_WIDTH   (DW),
    .ADDRESS_BITS (AW),
    .INDEX_BITS   (IW),
    .LATENCY      (2)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .read_i         (read),
    .read_address_i (read_address),
    .ready_o        (ready),
    .flush_i        (flush),
    .out_valid_o    (out_valid),
    .out_addr_o     (out_addr),
    .out_data_o     (out_data),
    .out_err_o      (out_err),
    .isp_write_i    (isp_write),
    .isp_address_i  (isp_address),
    .isp_data_i     (isp_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (out_valid) resp_q.push_back('{out_addr, out_data, out_err});
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic isp_wr(input logic [IW-1:0] idx, input logic [DW-1:0] val);
    isp_write   = 1'b1;
    isp_address = idx;
    isp_data    = val;
    tick();
    isp_write   = 1'b0;
  endtask

  task automatic check_resp(input string tag, input int idx, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic e);
    if (idx < resp_q.size()) begin
      check({tag, "_addr"}, 64'(resp_q[idx].addr), 64'(a));
      check({tag, "_data"}, 64'(resp_q[idx].data), 64'(d));
      check({tag, "_err"}, 64'(resp_q[idx].err), 64'(e));
    end else begin
      check({tag, "_present"}, 64'(resp_q.size()), 64'(idx + 1));
    end
  endtask

  initial begin
    int n;
    logic [DW-1:0] bad_data;
    logic          bad_err;

`ifdef IMEM_ERR_CHECK_EN
    bad_data = 32'h0000_0013;
    bad_err  = 1'b1;
`else
    bad_data = 32'h1111_0000;
    bad_err  = 1'b0;
`endif

    rst_n = 1'b0; read = 1'b0; read_address = '0; flush = 1'b0;
    isp_write = 1'b0; isp_address = '0; isp_data = '0;
    tick();
    tick();
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_addr", 64'(out_addr), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_err", 64'(out_err), 64'd0);
    rst_n = 1'b1;
    tick();
    check("rst_ready", 64'(ready), 64'd1);

    isp_wr(10'h000, 32'h1111_0000);
    isp_wr(10'h001, 32'h2222_1111);
    isp_wr(10'h002, 32'h3333_2222);
    isp_wr(10'h003, 32'hAAAA_AAAA);
    isp_wr(10'h004, 32'h4444_4444);
    isp_wr(10'h005, 32'h5555_5555);
    isp_wr(10'h010, 32'hDEAD_BEEF);
    isp_wr(10'h040, 32'h0BAD_F00D);

    // Single fetch: response two cycles after the request cycle.
    read = 1'b1; read_address = 20'h00040;
    tick();
    read = 1'b0;
    check("t1_lat1_valid", 64'(out_valid), 64'd0);
    tick();
    check("t1_valid", 64'(out_valid), 64'd1);
    check("t1_addr", 64'(out_addr), 64'h40);
    check("t1_data", 64'(out_data), 64'hDEADBEEF);
    check("t1_err", 64'(out_err), 64'd0);
    tick();
    check("t1_idle_valid", 64'(out_valid), 64'd0);
    check("t1_hold_data", 64'(out_data), 64'hDEADBEEF);
    check("t1_hold_addr", 64'(out_addr), 64'h40);

    // Back-to-back: ready drops for one cycle after the second accept.
    resp_q.delete();
    read = 1'b1; read_address = 20'h00000;
    tick();
    read_address = 20'h00004;
    tick();
    check("t2_ready_full", 64'(ready), 64'd0);
    read_address = 20'h00008;
    n = 0;
    while (!ready && n < 10) begin
      tick();
      n++;
    end
    check("t2_stall_cycles", 64'(n), 64'd1);
    tick();
    read = 1'b0;
    repeat (4) tick();
    check("t2_count", 64'(resp_q.size()), 64'd3);
    check_resp("t2_r0", 0, 20'h00000, 32'h1111_0000, 1'b0);
    check_resp("t2_r1", 1, 20'h00004, 32'h2222_1111, 1'b0);
    check_resp("t2_r2", 2, 20'h00008, 32'h3333_2222, 1'b0);

    // Flush with two outstanding; the blocked request is re-presented afterwards.
    read = 1'b1; read_address = 20'h00000;
    tick();
    read_address = 20'h00004;
    tick();
    flush = 1'b1; read_address = 20'h00100;
    check("t3a_ready_blocked", 64'(ready), 64'd0);
    tick();
    flush = 1'b0;
    resp_q.delete();
    check("t3a_after_flush_valid", 64'(out_valid), 64'd0);
    check("t3a_after_flush_ready", 64'(ready), 64'd1);
    tick();
    read = 1'b0;
    tick();
    check("t3a_valid", 64'(out_valid), 64'd1);
    tick();
    check("t3a_idle", 64'(out_valid), 64'd0);
    check("t3a_count", 64'(resp_q.size()), 64'd1);
    check_resp("t3a_r0", 0, 20'h00100, 32'h0BAD_F00D, 1'b0);
    // One accept from an empty responder must leave ready high.
    read = 1'b1; read_address = 20'h00000;
    tick();
    read = 1'b0;
    check("t3a_count_zero", 64'(ready), 64'd1);
    repeat (3) tick();

    // Request accepted in the flush cycle survives.
    resp_q.delete();
    read = 1'b1; read_address = 20'h00008;
    tick();
    flush = 1'b1; read_address = 20'h00100;
    check("t3b_ready", 64'(ready), 64'd1);
    tick();
    flush = 1'b0; read = 1'b0;
    check("t3b_after_flush_valid", 64'(out_valid), 64'd0);
    tick();
    check("t3b_valid", 64'(out_valid), 64'd1);
    check("t3b_addr", 64'(out_addr), 64'h100);
    tick();
    check("t3b_ready_after", 64'(ready), 64'd1);
    check("t3b_count", 64'(resp_q.size()), 64'd1);

    // ISP write colliding with a fetch of the same word returns the old word.
    read = 1'b1; read_address = 20'h0000C;
    isp_write = 1'b1; isp_address = 10'h003; isp_data = 32'h1234_5678;
    tick();
    read = 1'b0; isp_write = 1'b0;
    tick();
    check("t4_old_data", 64'(out_data), 64'hAAAAAAAA);
    tick();
    read = 1'b1; read_address = 20'h0000C;
    tick();
    read = 1'b0;
    tick();
    check("t4_new_data", 64'(out_data), 64'h12345678);
    tick();

    // Misaligned and out-of-range addresses.
    read = 1'b1; read_address = 20'h00002;
    tick();
    read_address = 20'h80000;
    tick();
    read = 1'b0;
    check("t5_mis_addr", 64'(out_addr), 64'h2);
    check("t5_mis_data", 64'(out_data), 64'(bad_data));
    check("t5_mis_err", 64'(out_err), 64'(bad_err));
    tick();
    check("t5_high_valid", 64'(out_valid), 64'd1);
    check("t5_high_addr", 64'(out_addr), 64'h80000);
    check("t5_high_data", 64'(out_data), 64'(bad_data));
    check("t5_high_err", 64'(out_err), 64'(bad_err));
    tick();

    // Asynchronous reset with two requests in flight.
    read = 1'b1; read_address = 20'h00010;
    tick();
    read_address = 20'h00014;
    tick();
    read = 1'b0;
    check("t6_inflight", 64'(out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    resp_q.delete();
    check("t6_rst_valid", 64'(out_valid), 64'd0);
    check("t6_rst_data", 64'(out_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) tick();
    check("t6_ready", 64'(ready), 64'd1);
    check("t6_no_stale", 64'(resp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
